window_meter: RTL and testbench

Measures the length, in ticks of the shared free-running timestamp counter, of each high window on a qualified activity input, such as the window generated by the counter FSM. Each completed window's length is delivered on a valid/ready output register. Windows longer than a programmable limit are aborted and flagged. The block sits on the consumer side of the timing-window path and is clocked from the same domain and counter as the window generator.

---
 rtl/window_meter.sv | 123 ++++++++++++
 tb/tb_window_meter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_meter.sv
// window_meter: measures each high window of i_active in timestamp ticks
// and hands the length to a consumer over a registered valid/ready output.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_ce           sample enable; the FSM and edge detector advance only here
//   i_ctr          shared free-running timestamp (+1 per i_ce cycle)
//   i_active       window input being measured
//   i_ready        consumer takes o_len this clock
//   o_len/o_valid  last completed window length and its valid flag
//   o_busy         measuring, or draining an aborted window
//   o_timeout      one-clock pulse: window exceeded MAX_COUNT and was aborted
//   o_overrun      one-clock pulse: a result was dropped (previous unconsumed)

module window_meter #(
  parameter int CTR_WIDTH = 22,
  parameter int MAX_COUNT = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic [CTR_WIDTH-1:0] i_ctr,
  input  logic                 i_active,
  input  logic                 i_ready,
  output logic [CTR_WIDTH-1:0] o_len,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic                 o_overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CTR_WIDTH-1:0] MAX_C =
    CTR_WIDTH'(MAX_COUNT);

  state_t               state;
  state_t               state_nx;
  logic                 act_q;
  logic [CTR_WIDTH-1:0] start;
  logic [CTR_WIDTH-1:0] start_nx;
  logic [CTR_WIDTH-1:0] elapsed;
  logic                 rise;
  logic                 fall;
  logic                 done;
  logic                 tmo_nx;
  logic                 accept;
  logic                 drop;

  // act_q resets high so a window already active at reset
  // release never produces a rise.
  assign rise = i_ce & i_active & ~act_q;
  assign fall = i_ce & ~i_active & act_q;

  // Modular subtraction absorbs counter wrap.
  assign elapsed = i_ctr - start;

  always_comb begin
    state_nx = state;
    start_nx = start;
    done     = 1'b0;
    tmo_nx   = 1'b0;
    if (i_ce) begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nx = MEASURE;
            start_nx = i_ctr;
          end
        end
        MEASURE: begin
          // A fall wins over a timeout on the same sample.
          if (fall) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else if (i_active && elapsed >= MAX_C) begin
            tmo_nx   = 1'b1;
            state_nx = DRAIN;
          end
        end
        DRAIN: begin
          if (!i_active) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Handshake runs every clock, independent of i_ce.
  assign accept = done & (~o_valid | i_ready);
  assign drop   = done & o_valid & ~i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      act_q     <= 1'b1;
      start     <= '0;
      o_len     <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nx;
      start     <= start_nx;
      o_busy    <= (state_nx != IDLE);
      o_timeout <= tmo_nx;
      o_overrun <= drop;
      if (i_ce) act_q <= i_active;
      if (accept) begin
        o_len   <= elapsed;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_meter.sv
// tb_window_meter: scenario tasks plus randomized traffic, each checked
// against a sample-counting reference model of window_meter.

module tb_window_meter;

  localparam int CW   = 4;
  localparam int MAXC = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_ce = 1'b0;
  logic [CW-1:0] i_ctr = '0;
  logic          i_active = 1'b0;
  logic          i_ready = 1'b1;
  logic [CW-1:0] o_len;
  logic          o_valid;
  logic          o_busy;
  logic          o_timeout;
  logic          o_overrun;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] ctr = '0;

  // Reference model: counts consecutive high samples of a window.
  bit            m_prev = 1'b1;
  bit            m_armed = 1'b0;
  bit            m_abort = 1'b0;
  int            m_run = 0;
  logic [CW-1:0] m_len = '0;
  bit            m_valid = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_tmo = 1'b0;
  bit            m_ovr = 1'b0;

  window_meter #(
    .CTR_WIDTH(CW),
    .MAX_COUNT(MAXC)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ce     (i_ce),
    .i_ctr    (i_ctr),
    .i_active (i_active),
    .i_ready  (i_ready),
    .o_len    (o_len),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_timeout(o_timeout),
    .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW+3:0] dut_v();
    return {o_len, o_valid, o_busy, o_timeout, o_overrun};
  endfunction

  function automatic logic [CW+3:0] mdl_v();
    return {m_len, m_valid, m_busy, m_tmo, m_ovr};
  endfunction

  function automatic void model(bit ce, bit act, bit rdy, bit rst);
    bit done;
    int res;
    done  = 1'b0;
    res   = 0;
    m_tmo = 1'b0;
    m_ovr = 1'b0;
    if (rst) begin
      m_prev  = 1'b1;
      m_armed = 1'b0;
      m_abort = 1'b0;
      m_run   = 0;
      m_len   = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      return;
    end
    if (ce) begin
      if (act && !m_prev) begin
        m_armed = 1'b1;
        m_abort = 1'b0;
        m_run   = 1;
      end else if (act && m_armed && !m_abort) begin
        if (m_run >= MAXC) begin
          m_tmo   = 1'b1;
          m_abort = 1'b1;
        end else begin
          m_run++;
        end
      end else if (!act && m_prev && m_armed) begin
        if (!m_abort) begin
          done = 1'b1;
          res  = m_run;
        end
        m_armed = 1'b0;
      end
      m_prev = act;
    end
    m_busy = m_armed;
    if (done) begin
      if (!m_valid || rdy) begin
        m_len   = CW'(res);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic step(input bit ce, input bit act,
                      input bit rdy, input bit rst);
    i_ce     = ce;
    i_active = act;
    i_ready  = rdy;
    i_rst    = rst;
    i_ctr    = ctr;
    @(posedge i_clk);
    model(ce, act, rdy, rst);
    if (ce) ctr++;
    #1;
  endtask

  task automatic idle_to(input logic [CW-1:0] v);
    int n;
    n = 0;
    while (ctr != v && n < 40) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      n++;
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (ctr != v && n < 40) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (ctr != v) begin
      errors++;
      $display("FAIL idle_to: got ctr %0d want %0d", ctr, v);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dut_v() !== '0) begin
      errors++;
      $display("FAIL reset: got %h want 0", dut_v());
    end
  endtask

  task automatic test_basic();
    int busy_n, val_n;
    logic [CW-1:0] got;
    busy_n = 0;
    val_n  = 0;
    got    = '0;
    idle_to(4'd10);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i < 5, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL basic step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      busy_n += int'(o_busy);
      if (o_valid) begin
        val_n++;
        got = o_len;
      end
    end
    checks++;
    if (got !== 4'd5 || val_n != 1 || busy_n != 5) begin
      errors++;
      $display("FAIL basic: got len %0d valid %0d busy %0d want 5 1 5",
               got, val_n, busy_n);
    end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] got;
    got = '0;
    idle_to(4'd14);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i < 5, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL wrap step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (o_valid) got = o_len;
    end
    checks++;
    if (got !== 4'd5) begin
      errors++;
      $display("FAIL wrap: got len %0d want 5", got);
    end
  endtask

  task automatic test_timeout();
    int tmo_n, tmo_at, val_n, busy_n;
    logic [CW-1:0] got;
    tmo_n  = 0;
    tmo_at = -1;
    val_n  = 0;
    busy_n = 0;
    got    = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL timeout step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (o_timeout) begin
        tmo_n++;
        tmo_at = i;
      end
      val_n  += int'(o_valid);
      busy_n += int'(o_busy);
    end
    checks++;
    if (tmo_n != 1 || tmo_at != MAXC || val_n != 0 || busy_n != 20) begin
      errors++;
      $display("FAIL timeout: got n %0d at %0d valid %0d busy %0d want 1 %0d 0 20",
               tmo_n, tmo_at, val_n, busy_n, MAXC);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i >= 1 && i < 4, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL timeout tail %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (i == 0 && o_busy !== 1'b0) begin
        errors++;
        $display("FAIL drain_exit: got busy %b want 0", o_busy);
      end
      if (o_valid) got = o_len;
    end
    checks++;
    if (got !== 4'd3) begin
      errors++;
      $display("FAIL after_timeout: got len %0d want 3", got);
    end
  endtask

  task automatic test_max_len();
    int tmo_n;
    logic [CW-1:0] got;
    tmo_n = 0;
    got   = '0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, i >= 1 && i <= MAXC, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL maxlen step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      tmo_n += int'(o_timeout);
      if (o_valid) got = o_len;
    end
    checks++;
    if (got !== CW'(MAXC) || tmo_n != 0) begin
      errors++;
      $display("FAIL maxlen: got len %0d tmo %0d want %0d 0",
               got, tmo_n, MAXC);
    end
  endtask

  task automatic test_backpressure();
    int ovr_n;
    ovr_n = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, (i >= 1 && i < 5) || (i >= 6 && i < 12), 1'b0, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL bp step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      ovr_n += int'(o_overrun);
    end
    checks++;
    if (ovr_n != 1 || o_len !== 4'd4 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got ovr %0d len %0d valid %b want 1 4 1",
               ovr_n, o_len, o_valid);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_len !== 4'd4) begin
      errors++;
      $display("FAIL bp_accept: got valid %b len %0d want 0 4",
               o_valid, o_len);
    end
  endtask

  task automatic test_sparse();
    logic [CW-1:0] got;
    bit ce, act;
    int k;
    got = '0;
    for (int i = 0; i < 33; i++) begin
      ce = (i % 3 == 0);
      k  = i / 3;
      if (ce) act = (k >= 1 && k <= 7);
      else if (i > 3 && i < 24) act = (i != 8);
      else act = (i == 25);
      step(ce, act, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL sparse step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (o_valid) got = o_len;
    end
    checks++;
    if (got !== 4'd7) begin
      errors++;
      $display("FAIL sparse: got len %0d want 7", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] q[$];
    for (int i = 0; i < 11; i++) begin
      step(1'b1, (i >= 1 && i < 4) || (i >= 5 && i < 9), 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL b2b step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (o_valid) q.push_back(o_len);
    end
    checks++;
    if (q.size() != 2 || q[0] !== 4'd3 || q[1] !== 4'd4) begin
      errors++;
      $display("FAIL b2b: got %0d results want 2 (3,4)", q.size());
    end
  endtask

  task automatic test_reset_mid();
    int val_n;
    val_n = 0;
    for (int i = 0; i < 4; i++) step(1'b1, i >= 1 && i < 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dut_v() !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", dut_v());
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i < 3, 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      val_n += int'(o_valid);
    end
    checks++;
    if (val_n != 0) begin
      errors++;
      $display("FAIL reset_mid_result: got valid %0d want 0", val_n);
    end
  endtask

  task automatic test_active_at_reset();
    int busy_n;
    logic [CW-1:0] got;
    busy_n = 0;
    got    = '0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i < 4 || (i >= 5 && i < 7), 1'b1, 1'b0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL act_rst step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
      if (i < 5) busy_n += int'(o_busy);
      if (o_valid) got = o_len;
    end
    checks++;
    if (busy_n != 0 || got !== 4'd2) begin
      errors++;
      $display("FAIL act_rst: got busy %0d len %0d want 0 2",
               busy_n, got);
    end
  endtask

  task automatic test_random();
    bit act;
    act = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4, 0) == 0) act = ~act;
      step($urandom_range(3, 0) != 0, act,
           $urandom_range(2, 0) != 0, $urandom_range(499, 0) == 0);
      checks++;
      if (dut_v() !== mdl_v()) begin
        errors++;
        $display("FAIL random step %0d: got %h want %h",
                 i, dut_v(), mdl_v());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_max_len();
    test_backpressure();
    test_sparse();
    test_back_to_back();
    test_reset_mid();
    test_active_at_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
